jp_lift_unit: RTL and testbench

Parallel JPEG-2000 5/3 lifting unit: three 1024×144 operand memories (left, sample, right neighbours, 16 packed 9-bit lanes per word), a 1024×10 result memory and a lane-serial lifting datapath. One `update_s` pulse captures a word from each operand memory and writes 16 lifted coefficients, one per cycle, into the result memory. Sits between the image loader (fills operand memories) and the wavelet pass controller (supplies per-lane flags, reads results).

---
 rtl/jp_lift_unit.sv | 162 ++++++++++++++++
 tb/tb_jp_lift_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jp_lift_unit.sv
// JPEG-2000 5/3 lifting unit: three operand memories feed a lane-serial
// predict/update datapath that sweeps 16 lanes into a result memory.
module jp_lift_unit (
    input  logic         clk_fast,
    input  logic         rst_n,
    input  logic [143:0] din_lf,
    input  logic [143:0] din_sa,
    input  logic [143:0] din_rt,
    input  logic [9:0]   addr_lf,
    input  logic [9:0]   addr_sa,
    input  logic [9:0]   addr_rt,
    input  logic         we_lf,
    input  logic         we_sa,
    input  logic         we_rt,
    output logic [143:0] dout_lf,
    output logic [143:0] dout_sa,
    output logic [143:0] dout_rt,
    input  logic [9:0]   din_res,
    input  logic [9:0]   addr_res,
    input  logic         we_res,
    output logic [9:0]   dout_res,
    input  logic [9:0]   op_addr,
    input  logic [9:0]   res_addr,
    input  logic [79:0]  flgs_s_i,
    input  logic         update_s,
    output logic         noupdate_s,
    output logic [9:0]   res_out_x
);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t state;
    state_t state_next;

    logic [3:0]   lane_cnt;
    logic [143:0] cap_lf;
    logic [143:0] cap_sa;
    logic [143:0] cap_rt;
    logic [79:0]  cap_flgs;
    logic [9:0]   cap_base;

    logic [143:0] mem_lf [0:1023];
    logic [143:0] mem_sa [0:1023];
    logic [143:0] mem_rt [0:1023];
    logic [9:0]   mem_res [0:1023];

    logic [7:0]         lane_lo;
    logic [6:0]         flag_lo;
    logic [8:0]         l_raw;
    logic [8:0]         s_raw;
    logic [8:0]         r_raw;
    logic [4:0]         flag;
    logic signed [11:0] l_ext;
    logic signed [11:0] s_ext;
    logic signed [11:0] r_ext;
    logic signed [11:0] pair_sum;
    logic signed [11:0] predict;
    logic signed [11:0] update;
    logic signed [11:0] lane_wide;
    logic [9:0]         res_wr_addr;
    logic               unused_wide_bits;

    assign dout_lf    = mem_lf[addr_lf];
    assign dout_sa    = mem_sa[addr_sa];
    assign dout_rt    = mem_rt[addr_rt];
    assign dout_res   = mem_res[addr_res];
    assign noupdate_s = (state == IDLE);

    // Operand memories are never cleared; the loader owns their contents.
    always_ff @(posedge clk_fast) begin
        if (we_lf) mem_lf[addr_lf] <= din_lf;
    end

    always_ff @(posedge clk_fast) begin
        if (we_sa) mem_sa[addr_sa] <= din_sa;
    end

    always_ff @(posedge clk_fast) begin
        if (we_rt) mem_rt[addr_rt] <= din_rt;
    end

    // The sweep owns the result port while busy; external writes are dropped.
    always_ff @(posedge clk_fast) begin
        if (state == SWEEP) begin
            mem_res[res_wr_addr] <= lane_wide[9:0];
        end else if (we_res) begin
            mem_res[addr_res] <= din_res;
        end
    end

    always_comb begin
        lane_lo     = {4'd0, lane_cnt} * 8'd9;
        flag_lo     = {3'd0, lane_cnt} * 7'd5;
        l_raw       = cap_lf[lane_lo +: 9];
        s_raw       = cap_sa[lane_lo +: 9];
        r_raw       = cap_rt[lane_lo +: 9];
        flag        = cap_flgs[flag_lo +: 5];
        l_ext       = {{3{l_raw[8]}}, l_raw};
        s_ext       = {{3{s_raw[8]}}, s_raw};
        r_ext       = {{3{r_raw[8]}}, r_raw};
        pair_sum    = l_ext + r_ext;
        predict     = pair_sum >>> 1;
        update      = (pair_sum + 12'sd2) >>> 2;
        res_wr_addr = cap_base + {6'd0, lane_cnt};
    end

    // 12 bits cannot overflow for 9-bit lanes; only the low 10 bits are kept.
    always_comb begin
        lane_wide = s_ext;
        case (flag)
            5'd7:    lane_wide = s_ext - predict;
            5'd5:    lane_wide = s_ext + predict;
            5'd6:    lane_wide = s_ext + update;
            5'd4:    lane_wide = s_ext - update;
            default: lane_wide = s_ext;
        endcase
    end

    assign unused_wide_bits = ^lane_wide[11:10];

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (update_s) state_next = SWEEP;
            SWEEP: if (lane_cnt == 4'd15) state_next = IDLE;
        endcase
    end

    // Capture everything at start so later operand writes cannot disturb a sweep.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt  <= 4'd0;
            res_out_x <= 10'd0;
            cap_lf    <= '0;
            cap_sa    <= '0;
            cap_rt    <= '0;
            cap_flgs  <= '0;
            cap_base  <= 10'd0;
        end else if (state == IDLE) begin
            if (update_s) begin
                cap_lf   <= mem_lf[op_addr];
                cap_sa   <= mem_sa[op_addr];
                cap_rt   <= mem_rt[op_addr];
                cap_flgs <= flgs_s_i;
                cap_base <= res_addr;
                lane_cnt <= 4'd0;
            end
        end else begin
            res_out_x <= lane_wide[9:0];
            lane_cnt  <= lane_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_jp_lift_unit.sv
// Randomized self-checking bench for jp_lift_unit against an arithmetic
// reference model of the 5/3 lifting rules and the memory contents.
module tb_jp_lift_unit;

    logic         clk_fast = 1'b0;
    logic         rst_n = 1'b0;
    logic [143:0] din_lf = '0, din_sa = '0, din_rt = '0;
    logic [9:0]   addr_lf = '0, addr_sa = '0, addr_rt = '0;
    logic         we_lf = 1'b0, we_sa = 1'b0, we_rt = 1'b0;
    logic [143:0] dout_lf, dout_sa, dout_rt;
    logic [9:0]   din_res = '0, addr_res = '0;
    logic         we_res = 1'b0;
    logic [9:0]   dout_res;
    logic [9:0]   op_addr = '0, res_addr = '0;
    logic [79:0]  flgs_s_i = '0;
    logic         update_s = 1'b0;
    logic         noupdate_s;
    logic [9:0]   res_out_x;

    int checks = 0;
    int errors = 0;

    logic [143:0] mlf [int];
    logic [143:0] msa [int];
    logic [143:0] mrt [int];
    logic [9:0]   mres [0:1023];
    int           addr_pool [$];

    jp_lift_unit dut (
        .clk_fast(clk_fast), .rst_n(rst_n),
        .din_lf(din_lf), .din_sa(din_sa), .din_rt(din_rt),
        .addr_lf(addr_lf), .addr_sa(addr_sa), .addr_rt(addr_rt),
        .we_lf(we_lf), .we_sa(we_sa), .we_rt(we_rt),
        .dout_lf(dout_lf), .dout_sa(dout_sa), .dout_rt(dout_rt),
        .din_res(din_res), .addr_res(addr_res), .we_res(we_res), .dout_res(dout_res),
        .op_addr(op_addr), .res_addr(res_addr), .flgs_s_i(flgs_s_i),
        .update_s(update_s), .noupdate_s(noupdate_s), .res_out_x(res_out_x)
    );

    always #5 clk_fast = ~clk_fast;

    task automatic checkOutput(input string tag, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int floorDiv(input int n, input int d);
        int q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int laneOf(input logic [143:0] w, input int k);
        logic [8:0] raw;
        raw = w[9*k +: 9];
        return raw[8] ? int'(raw) - 512 : int'(raw);
    endfunction

    function automatic logic [9:0] liftModel(input int l, input int s, input int r, input logic [4:0] f);
        int v;
        case (f)
            5'd7:    v = s - floorDiv(l + r, 2);
            5'd5:    v = s + floorDiv(l + r, 2);
            5'd6:    v = s + floorDiv(l + r + 2, 4);
            5'd4:    v = s - floorDiv(l + r + 2, 4);
            default: v = s;
        endcase
        return 10'(v & 32'h3FF);
    endfunction

    function automatic logic [143:0] randWord();
        logic [159:0] w;
        w = '0;
        for (int i = 0; i < 5; i++) w = {w[127:0], 32'($urandom)};
        return w[143:0];
    endfunction

    function automatic logic [79:0] randFlags();
        logic [79:0] f;
        int pick;
        for (int k = 0; k < 16; k++) begin
            pick = int'($urandom_range(0, 5));
            f[5*k +: 5] = (pick < 4) ? 5'(4 + pick) : 5'($urandom);
        end
        return f;
    endfunction

    task automatic writeOperands(input logic [9:0] a, input logic [143:0] l, input logic [143:0] s, input logic [143:0] r);
        @(negedge clk_fast);
        addr_lf = a; addr_sa = a; addr_rt = a;
        din_lf = l; din_sa = s; din_rt = r;
        we_lf = 1'b1; we_sa = 1'b1; we_rt = 1'b1;
        @(negedge clk_fast);
        we_lf = 1'b0; we_sa = 1'b0; we_rt = 1'b0;
        if (!mlf.exists(int'(a))) addr_pool.push_back(int'(a));
        mlf[int'(a)] = l; msa[int'(a)] = s; mrt[int'(a)] = r;
    endtask

    task automatic writeResult(input logic [9:0] a, input logic [9:0] d);
        @(negedge clk_fast);
        addr_res = a; din_res = d; we_res = 1'b1;
        @(negedge clk_fast);
        we_res = 1'b0;
        mres[a] = d;
    endtask

    task automatic checkResult(input string tag, input logic [9:0] a);
        addr_res = a;
        #1;
        checkOutput(tag, 144'(dout_res), 144'(mres[a]));
    endtask

    // Drives one sweep; optionally writes the sample word at the start edge and
    // injects a start request plus an external result write mid-sweep.
    task automatic applyStimulus(input logic [9:0] op, input logic [9:0] base, input logic [79:0] flgs,
                                 input bit hazard, input int inject_at);
        logic [9:0]   expected [16];
        logic [143:0] new_sa;
        int cnt;
        for (int k = 0; k < 16; k++)
            expected[k] = liftModel(laneOf(mlf[int'(op)], k), laneOf(msa[int'(op)], k),
                                    laneOf(mrt[int'(op)], k), flgs[5*k +: 5]);
        new_sa = randWord();
        @(negedge clk_fast);
        op_addr = op; res_addr = base; flgs_s_i = flgs; update_s = 1'b1;
        if (hazard) begin
            addr_sa = op; din_sa = new_sa; we_sa = 1'b1;
        end
        @(negedge clk_fast);
        update_s = 1'b0; we_sa = 1'b0;
        if (hazard) msa[int'(op)] = new_sa;
        op_addr = 10'($urandom); res_addr = 10'($urandom); flgs_s_i = randFlags();
        checkOutput("busy_start", 144'(noupdate_s), 144'(0));
        cnt = 0;
        while (noupdate_s === 1'b0 && cnt < 40) begin
            if (cnt == inject_at) begin
                update_s = 1'b1; we_res = 1'b1; addr_res = base; din_res = ~expected[0];
            end
            @(negedge clk_fast);
            cnt++;
            update_s = 1'b0; we_res = 1'b0;
        end
        checkOutput("busy_cycles", 144'(cnt), 144'(16));
        for (int k = 0; k < 16; k++) mres[base + 10'(k)] = expected[k];
        checkOutput("res_out_x", 144'(res_out_x), 144'(expected[15]));
        for (int k = 0; k < 16; k++) checkResult($sformatf("result_lane%0d", k), base + 10'(k));
    endtask

    task automatic resetMidSweep(input logic [9:0] op, input logic [9:0] base);
        logic [9:0] expected [16];
        logic [79:0] flgs;
        flgs = randFlags();
        for (int k = 0; k < 16; k++) begin
            expected[k] = liftModel(laneOf(mlf[int'(op)], k), laneOf(msa[int'(op)], k),
                                    laneOf(mrt[int'(op)], k), flgs[5*k +: 5]);
            writeResult(base + 10'(k), ~expected[k]);
        end
        @(negedge clk_fast);
        op_addr = op; res_addr = base; flgs_s_i = flgs; update_s = 1'b1;
        @(negedge clk_fast);
        update_s = 1'b0;
        repeat (5) @(negedge clk_fast);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_noupdate", 144'(noupdate_s), 144'(1));
        checkOutput("rst_res_out_x", 144'(res_out_x), 144'(0));
        for (int k = 0; k < 5; k++) mres[base + 10'(k)] = expected[k];
        repeat (2) @(negedge clk_fast);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_fast);
        checkOutput("rst_stay_idle", 144'(noupdate_s), 144'(1));
        for (int k = 0; k < 16; k++) checkResult($sformatf("rst_lane%0d", k), base + 10'(k));
        addr_lf = op; addr_sa = op; addr_rt = op;
        #1;
        checkOutput("rst_keep_lf", dout_lf, mlf[int'(op)]);
        checkOutput("rst_keep_sa", dout_sa, msa[int'(op)]);
        checkOutput("rst_keep_rt", dout_rt, mrt[int'(op)]);
    endtask

    initial begin
        logic [4:0]  dir_flag [5];
        logic [9:0]  dir_exp [5];
        logic [79:0] flgs;
        logic [9:0]  a;

        dir_flag = '{5'd7, 5'd6, 5'd5, 5'd4, 5'd0};
        dir_exp  = '{10'h3FC, 10'd56, 10'd76, 10'd16, 10'd36};
        for (int i = 0; i < 1024; i++) mres[i] = '0;

        repeat (3) @(negedge clk_fast);
        checkOutput("reset_noupdate", 144'(noupdate_s), 144'(1));
        checkOutput("reset_res_out_x", 144'(res_out_x), 144'(0));
        rst_n = 1'b1;
        @(negedge clk_fast);
        checkOutput("post_reset_noupdate", 144'(noupdate_s), 144'(1));

        writeOperands(10'd0, 144'h1a0d068341a0b088542e0b0581c120905824,
                             144'h160b068341a0b068442a1106824120b05824,
                             144'h160b068341a0d058442a170582c0e090482c);
        addr_lf = 10'd0; addr_sa = 10'd0; addr_rt = 10'd0;
        #1;
        checkOutput("readback_lf", dout_lf, 144'h1a0d068341a0b088542e0b0581c120905824);
        checkOutput("readback_sa", dout_sa, 144'h160b068341a0b068442a1106824120b05824);
        checkOutput("readback_rt", dout_rt, 144'h160b068341a0d058442a170582c0e090482c);

        for (int i = 0; i < 5; i++) begin
            flgs = randFlags();
            flgs[4:0] = dir_flag[i];
            applyStimulus(10'd0, 10'd0, flgs, 1'b0, -1);
            addr_res = 10'd0;
            #1;
            checkOutput($sformatf("directed_flag%0d", dir_flag[i]), 144'(dout_res), 144'(dir_exp[i]));
        end

        for (int i = 0; i < 6; i++) begin
            a = 10'($urandom_range(1, 1023));
            writeOperands(a, randWord(), randWord(), randWord());
        end

        applyStimulus(10'(addr_pool[1]), 10'd1020, randFlags(), 1'b0, -1);

        for (int i = 0; i < 8; i++) begin
            a = 10'(addr_pool[$urandom_range(0, addr_pool.size() - 1)]);
            applyStimulus(a, (i % 3 == 0) ? 10'($urandom_range(1008, 1023)) : 10'($urandom),
                          randFlags(), (i % 2 == 1), -1);
        end

        applyStimulus(10'd0, 10'd0, randFlags(), 1'b0, 3);

        resetMidSweep(10'(addr_pool[2]), 10'd200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
